vga_sync_decoder: RTL

Receive-side counterpart of the 480p display timing generator: consumes a raw pixel stream (hsync, vsync, de, 8-bit RGB) and recovers per-pixel screen coordinates, line/frame strobes and measured geometry. A lock state machine confirms that the incoming geometry matches the expected resolution. The block sits on the pixel clock domain and feeds pixel-indexed consumers (frame buffer writer, checksum/compare logic in the verilator bench) that need `sx`/`sy` derived from sync alone.

---
 rtl/vga_sync_decoder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, line/frame strobes, geometry and lock state from a raw sync/de/RGB stream
// Ports: clk_pix/rst_pix_n pixel clock and async active-low reset; hsync/vsync/de/r_in/g_in/b_in raw input stream;
//        sx/sy/px_valid/r_out/g_out/b_out pixel-aligned coordinates and colour; line_start/frame_start strobes;
//        line_len/frame_lines measured geometry; locked geometry confirmed; sync_err one-cycle error pulse.
module vga_sync_decoder #(
    parameter int CORDW       = 10,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic [7:0]       r_in,
    input  logic [7:0]       g_in,
    input  logic [7:0]       b_in,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             px_valid,
    output logic [7:0]       r_out,
    output logic [7:0]       g_out,
    output logic [7:0]       b_out,
    output logic             line_start,
    output logic             frame_start,
    output logic [CORDW-1:0] line_len,
    output logic [CORDW-1:0] frame_lines,
    output logic             locked,
    output logic             sync_err
);
    localparam int CW = $clog2(LOCK_FRAMES + 1);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] TRAIN  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [CORDW-1:0] MAX = '1;

    logic             hs1_q, vs1_q, de1_q, de_p_q, vs_p_q;
    logic [23:0]      rgb1_q, rgb_q;
    logic [CORDW-1:0] sx_q, sx_d, sy_q, sy_d, ll_q, ll_d, fl_q, fl_d;
    logic             pv_q, ls_q, fs_q, lk_q, err_q, err_d;
    logic             lbad_q, lbad_d, fbad_q, fbad_d, ovf_q, ovf_d;
    logic [1:0]       st_q, st_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rise, fall, fs_ev, hs_err, sat, line_bad, clean, lock_err;
    logic [CORDW-1:0] sx_inc, sy_inc, lines;

    always_comb begin
        rise     = de1_q & ~de_p_q;
        fall     = ~de1_q & de_p_q;
        fs_ev    = vs1_q & ~vs_p_q;
        hs_err   = de1_q & hs1_q;
        // ovf_q limits the overflow error to one pulse per line
        sat      = de1_q & ~rise & (sx_q == MAX) & ~ovf_q;
        sx_inc   = (sx_q == MAX) ? MAX : sx_q + 1'b1;
        sy_inc   = (sy_q == MAX) ? MAX : sy_q + 1'b1;
        line_bad = fall & (lbad_q | (sx_inc != CORDW'(H_RES)));
        // a line ending in the same cycle as the vsync edge belongs to the closing frame
        lines    = fall ? sy_inc : sy_q;
        clean    = (lines == CORDW'(V_RES)) & ~fbad_q & ~line_bad;
        sx_d     = rise ? '0 : de1_q ? sx_inc : sx_q;
        sy_d     = fs_ev ? '0 : fall ? sy_inc : sy_q;
        ll_d     = fall ? sx_inc : ll_q;
        fl_d     = fs_ev ? lines : fl_q;
        ovf_d    = ~rise & (ovf_q | sat);
        lbad_d   = rise ? hs_err : lbad_q | hs_err;
        fbad_d   = ~fs_ev & (fbad_q | line_bad);
        st_d     = st_q;
        cnt_d    = cnt_q;
        lock_err = 1'b0;
        if (line_bad && st_q == LOCKED) begin
            st_d     = TRAIN;
            cnt_d    = '0;
            lock_err = 1'b1;
        end
        if (fs_ev) begin
            if (st_d == SEARCH) begin
                st_d  = TRAIN;
                cnt_d = '0;
            end else if (!clean) begin
                st_d     = TRAIN;
                cnt_d    = '0;
                lock_err = 1'b1;
            end else if (st_d == TRAIN) begin
                cnt_d = cnt_q + 1'b1;
                st_d  = (cnt_d == CW'(LOCK_FRAMES)) ? LOCKED : TRAIN;
            end
        end
        err_d = sat | hs_err | (fall & (sy_q == MAX)) | lock_err;
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            de1_q  <= 1'b0;
            de_p_q <= 1'b0;
            vs_p_q <= 1'b0;
            rgb1_q <= '0;
            rgb_q  <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            ll_q   <= '0;
            fl_q   <= '0;
            pv_q   <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            lk_q   <= 1'b0;
            err_q  <= 1'b0;
            lbad_q <= 1'b0;
            fbad_q <= 1'b0;
            ovf_q  <= 1'b0;
            st_q   <= SEARCH;
            cnt_q  <= '0;
        end else begin
            hs1_q  <= SYNC_POL ? hsync : ~hsync;
            vs1_q  <= SYNC_POL ? vsync : ~vsync;
            de1_q  <= de;
            de_p_q <= de1_q;
            vs_p_q <= vs1_q;
            rgb1_q <= {r_in, g_in, b_in};
            rgb_q  <= rgb1_q;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            ll_q   <= ll_d;
            fl_q   <= fl_d;
            pv_q   <= de1_q;
            ls_q   <= rise;
            fs_q   <= fs_ev;
            // locked trails the state so a drop shows up the cycle after its error pulse
            lk_q   <= (st_q == LOCKED);
            err_q  <= err_d;
            lbad_q <= lbad_d;
            fbad_q <= fbad_d;
            ovf_q  <= ovf_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sx                    = sx_q;
    assign sy                    = sy_q;
    assign px_valid              = pv_q;
    assign {r_out, g_out, b_out} = rgb_q;
    assign line_start            = ls_q;
    assign frame_start           = fs_q;
    assign line_len              = ll_q;
    assign frame_lines           = fl_q;
    assign locked                = lk_q;
    assign sync_err              = err_q;
endmodule
